// File: rtl/matrix_mult_stream.sv
// Streaming N x N matrix multiplier: row-major operand load, a two-stage multiply/adder-tree
// compute pass that fills the C buffer, then a backpressured drain of C in row-major order.
module matrix_mult_stream #(
    parameter int N      = 3,
    parameter int DW     = 8,
    parameter bit SIGNED = 1'b0,
    localparam int OW    = 2*DW + $clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_a,
    input  logic [DW-1:0] in_b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] out_data,
    output logic          out_last,
    output logic          busy
);
    localparam int RW = $clog2(N);
    localparam int CW = $clog2(N*N + 2);
    localparam int PW = 2*DW;

    typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DRAIN} state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] a_q [N][N];
    logic [DW-1:0] b_q [N][N];
    logic [OW-1:0] c_q [N][N];
    logic [RW-1:0] lr_q, lc_q, lr_d, lc_d;
    logic [RW-1:0] ci_q, cj_q, ci_d, cj_d;
    logic [RW-1:0] oi_q, oj_q, oi_d, oj_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          s1_vld_q;
    logic [RW-1:0] s1_i_q, s1_j_q;
    logic [PW-1:0] prod_s [N];
    logic [PW-1:0] prod_q [N];
    logic [OW-1:0] psum_s [N+1];
    logic          out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic [OW-1:0] out_data_q, out_data_d;
    logic          in_fire_s, issue_s;

    function automatic logic [PW-1:0] mul_f(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [PW-1:0] ea;
        logic [PW-1:0] eb;
        if (SIGNED) begin
            ea = {{DW{a[DW-1]}}, a};
            eb = {{DW{b[DW-1]}}, b};
        end else begin
            ea = {{DW{1'b0}}, a};
            eb = {{DW{1'b0}}, b};
        end
        // Low PW bits of the extended product are exact in both modes.
        return ea * eb;
    endfunction

    function automatic logic [OW-1:0] ext_f(input logic [PW-1:0] p);
        if (SIGNED) begin
            return {{(OW-PW){p[PW-1]}}, p};
        end else begin
            return {{(OW-PW){1'b0}}, p};
        end
    endfunction

    assign in_ready  = ((state_q == IDLE) || (state_q == LOAD)) && !reset;
    assign in_fire_s = in_valid && in_ready;
    assign issue_s   = (state_q == COMPUTE) && (cnt_q < CW'(N*N));
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

    assign psum_s[0] = '0;
    for (genvar t = 0; t < N; t++) begin : g_lane
        assign prod_s[t]   = mul_f(a_q[ci_q][t], b_q[t][cj_q]);
        assign psum_s[t+1] = psum_s[t] + ext_f(prod_q[t]);
    end

    // Next-state, index and output-register logic.
    always_comb begin
        state_d     = state_q;
        lr_d        = lr_q;
        lc_d        = lc_q;
        ci_d        = ci_q;
        cj_d        = cj_q;
        oi_d        = oi_q;
        oj_d        = oj_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        if (in_fire_s) begin
            lc_d = (lc_q == RW'(N-1)) ? '0 : lc_q + 1'b1;
            lr_d = (lc_q == RW'(N-1)) ? ((lr_q == RW'(N-1)) ? '0 : lr_q + 1'b1) : lr_q;
        end else begin
            lc_d = lc_q;
        end
        case (state_q)
            IDLE: begin
                if (in_fire_s) begin
                    state_d = LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                if (in_fire_s && (lr_q == RW'(N-1)) && (lc_q == RW'(N-1))) begin
                    state_d = COMPUTE;
                    cnt_d   = '0;
                end else begin
                    state_d = LOAD;
                end
            end
            COMPUTE: begin
                cnt_d = cnt_q + 1'b1;
                if (issue_s) begin
                    cj_d = (cj_q == RW'(N-1)) ? '0 : cj_q + 1'b1;
                    ci_d = (cj_q == RW'(N-1)) ? ((ci_q == RW'(N-1)) ? '0 : ci_q + 1'b1) : ci_q;
                end else begin
                    cj_d = cj_q;
                end
                // Two extra cycles let the final product pass both pipeline stages.
                if (cnt_q == CW'(N*N + 1)) begin
                    state_d     = DRAIN;
                    cnt_d       = '0;
                    oi_d        = '0;
                    oj_d        = '0;
                    out_valid_d = 1'b1;
                    out_last_d  = 1'b0;
                    out_data_d  = c_q[0][0];
                end else begin
                    state_d = COMPUTE;
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    oj_d = (oj_q == RW'(N-1)) ? '0 : oj_q + 1'b1;
                    oi_d = (oj_q == RW'(N-1)) ? ((oi_q == RW'(N-1)) ? '0 : oi_q + 1'b1) : oi_q;
                    if (out_last_q) begin
                        state_d     = IDLE;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                    end else begin
                        out_data_d = c_q[oi_d][oj_d];
                        out_last_d = (oi_d == RW'(N-1)) && (oj_d == RW'(N-1));
                    end
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
            end
        endcase
    end

    // State, buffers and the two compute pipeline stages.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            lr_q        <= '0;
            lc_q        <= '0;
            ci_q        <= '0;
            cj_q        <= '0;
            oi_q        <= '0;
            oj_q        <= '0;
            cnt_q       <= '0;
            s1_vld_q    <= 1'b0;
            s1_i_q      <= '0;
            s1_j_q      <= '0;
            prod_q      <= '{default: '0};
            c_q         <= '{default: '0};
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            lr_q        <= lr_d;
            lc_q        <= lc_d;
            ci_q        <= ci_d;
            cj_q        <= cj_d;
            oi_q        <= oi_d;
            oj_q        <= oj_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
            if (in_fire_s) begin
                a_q[lr_q][lc_q] <= in_a;
                b_q[lr_q][lc_q] <= in_b;
            end
            s1_vld_q <= issue_s;
            if (issue_s) begin
                prod_q <= prod_s;
                s1_i_q <= ci_q;
                s1_j_q <= cj_q;
            end
            if (s1_vld_q) begin
                c_q[s1_i_q][s1_j_q] <= psum_s[N];
            end
        end
    end
endmodule

// File: tb/tb_matrix_mult_stream.sv
// Directed bench for matrix_mult_stream: unsigned 3x3/8-bit, signed 3x3/8-bit and unsigned
// 4x4/4-bit instances driven through load, latency, drain, backpressure and reset scenarios.
module tb_matrix_mult_stream;
    logic        clk = 1'b0;
    logic        reset;
    logic        iv [3];
    logic        ir [3];
    logic        ov [3];
    logic        orr [3];
    logic        ol [3];
    logic        bz [3];
    logic [7:0]  ia [3];
    logic [7:0]  ib [3];
    logic [17:0] od0, od1;
    logic [9:0]  od2;
    int          compared = 0;
    int          mismatched = 0;
    int          av [16];
    int          bv [16];
    int          ev [16];
    int          nn [3] = '{9, 9, 16};

    always #5 clk = ~clk;

    matrix_mult_stream #(.N(3), .DW(8), .SIGNED(1'b0)) u_dut0 (
        .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(ir[0]), .in_a(ia[0]), .in_b(ib[0]),
        .out_valid(ov[0]), .out_ready(orr[0]), .out_data(od0), .out_last(ol[0]), .busy(bz[0]));
    matrix_mult_stream #(.N(3), .DW(8), .SIGNED(1'b1)) u_dut1 (
        .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(ir[1]), .in_a(ia[1]), .in_b(ib[1]),
        .out_valid(ov[1]), .out_ready(orr[1]), .out_data(od1), .out_last(ol[1]), .busy(bz[1]));
    matrix_mult_stream #(.N(4), .DW(4), .SIGNED(1'b0)) u_dut2 (
        .clk(clk), .reset(reset), .in_valid(iv[2]), .in_ready(ir[2]), .in_a(ia[2][3:0]),
        .in_b(ib[2][3:0]), .out_valid(ov[2]), .out_ready(orr[2]), .out_data(od2), .out_last(ol[2]),
        .busy(bz[2]));

    function automatic logic [63:0] get_od(input int sel);
        case (sel)
            0:       return 64'(od0);
            1:       return 64'(od1);
            default: return 64'(od2);
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_ev9(input int e0, input int e1, input int e2, input int e3, input int e4,
                           input int e5, input int e6, input int e7, input int e8);
        ev[0] = e0; ev[1] = e1; ev[2] = e2; ev[3] = e3; ev[4] = e4;
        ev[5] = e5; ev[6] = e6; ev[7] = e7; ev[8] = e8;
    endtask

    task automatic load(input int sel, input int cnt, input int gap_pct);
        int   k = 0;
        int   guard = 0;
        logic v;
        while (k < cnt && guard < 2000) begin
            @(negedge clk);
            guard++;
            if (k > 0) chk("busy_load", 64'(bz[sel]), 64'd1);
            v = ($urandom_range(99) >= gap_pct);
            iv[sel] = v;
            ia[sel] = 8'(av[k]);
            ib[sel] = 8'(bv[k]);
            #1;
            if (v && ir[sel]) k++;
        end
        chk("load_beats", 64'(k), 64'(cnt));
    endtask

    // Junk held on the input while not ready must never be consumed.
    task automatic wait_first(input int sel);
        int m = 0;
        do begin
            @(negedge clk);
            m++;
            iv[sel] = 1'b1;
            ia[sel] = 8'hA5;
            ib[sel] = 8'h5A;
            orr[sel] = 1'b0;
            if (m == 1) chk("ready_low_compute", 64'(ir[sel]), 64'd0);
        end while (!ov[sel] && m < 300);
        iv[sel] = 1'b0;
        chk("first_valid_latency", 64'(m), 64'(nn[sel] + 3));
    endtask

    task automatic drain(input int sel, input int ntake, input int rdy_pct);
        int          got = 0;
        int          guard = 0;
        logic        r;
        logic        pst = 1'b0;
        logic [63:0] pd = '0;
        logic        pl = 1'b0;
        while (got < ntake && guard < 600) begin
            if (guard > 0) @(negedge clk);
            guard++;
            r = ($urandom_range(99) < rdy_pct);
            orr[sel] = r;
            chk("valid_in_drain", 64'(ov[sel]), 64'd1);
            chk("busy_drain", 64'(bz[sel]), 64'd1);
            if (pst) begin
                chk("data_stable", get_od(sel), pd);
                chk("last_stable", 64'(ol[sel]), 64'(pl));
            end
            if (r) begin
                chk("data", get_od(sel), 64'(ev[got]));
                chk("last", 64'(ol[sel]), 64'(got == nn[sel] - 1));
                got++;
            end
            pst = !r;
            pd  = get_od(sel);
            pl  = ol[sel];
        end
        chk("drain_count", 64'(got), 64'(ntake));
    endtask

    task automatic after_drain(input int sel);
        @(negedge clk);
        orr[sel] = 1'b0;
        chk("valid_after", 64'(ov[sel]), 64'd0);
        chk("busy_after", 64'(bz[sel]), 64'd0);
        chk("ready_after", 64'(ir[sel]), 64'd1);
    endtask

    task automatic full_run(input int sel, input int gap_pct, input int rdy_pct);
        load(sel, nn[sel], gap_pct);
        wait_first(sel);
        drain(sel, nn[sel], rdy_pct);
        after_drain(sel);
    endtask

    initial begin
        reset = 1'b1;
        for (int s = 0; s < 3; s++) begin
            iv[s] = 1'b0; orr[s] = 1'b0; ia[s] = 8'h00; ib[s] = 8'h00;
        end
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            chk("rst_in_ready", 64'(ir[s]), 64'd0);
            chk("rst_out_valid", 64'(ov[s]), 64'd0);
            chk("rst_out_last", 64'(ol[s]), 64'd0);
            chk("rst_out_data", get_od(s), 64'd0);
            chk("rst_busy", 64'(bz[s]), 64'd0);
        end
        reset = 1'b0;
        #1;
        chk("ready_after_reset", 64'(ir[0]), 64'd1);

        // Unsigned 3x3: A = 1..9, B = 9..1.
        for (int i = 0; i < 9; i++) begin av[i] = i + 1; bv[i] = 9 - i; end
        set_ev9(30, 24, 18, 84, 69, 54, 138, 114, 90);
        full_run(0, 0, 100);
        full_run(0, 40, 50);

        // Unsigned extreme values.
        for (int i = 0; i < 9; i++) begin av[i] = 255; bv[i] = 255; ev[i] = 195075; end
        full_run(0, 0, 100);

        // Reset after four beats, then identity times 1..9.
        for (int i = 0; i < 9; i++) begin av[i] = 7; bv[i] = 7; end
        load(0, 4, 0);
        @(negedge clk);
        iv[0] = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("ready_after_midload_rst", 64'(ir[0]), 64'd1);
        for (int i = 0; i < 9; i++) begin
            av[i] = (i % 4 == 0) ? 1 : 0;
            bv[i] = i + 1;
            ev[i] = i + 1;
        end
        full_run(0, 0, 100);

        // Reset after two drained outputs, then a fresh run.
        for (int i = 0; i < 9; i++) begin av[i] = i + 1; bv[i] = 9 - i; end
        set_ev9(30, 24, 18, 84, 69, 54, 138, 114, 90);
        load(0, 9, 0);
        wait_first(0);
        drain(0, 2, 100);
        @(negedge clk);
        orr[0] = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("valid_after_drain_rst", 64'(ov[0]), 64'd0);
        chk("busy_after_drain_rst", 64'(bz[0]), 64'd0);
        reset = 1'b0;
        for (int i = 0; i < 9; i++) begin
            av[i] = (i % 4 == 0) ? 1 : 0;
            bv[i] = 9 - i;
            ev[i] = 9 - i;
        end
        full_run(0, 0, 100);

        // Signed 3x3: -128 * -128 summed three times, then -1 * 2 summed three times.
        for (int i = 0; i < 9; i++) begin av[i] = -128; bv[i] = -128; ev[i] = 49152; end
        full_run(1, 0, 100);
        for (int i = 0; i < 9; i++) begin av[i] = -1; bv[i] = 2; ev[i] = 262138; end
        full_run(1, 20, 70);

        // Unsigned 4x4, 4-bit: all 15.
        for (int i = 0; i < 16; i++) begin av[i] = 15; bv[i] = 15; ev[i] = 900; end
        full_run(2, 0, 100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
